// File: rtl/core_seq_pkg.sv
// Shared types for the execution-phase sequencer: phase encoding and the
// Moore strobe decode used by the top-level FSM.
package core_seq_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_FETCH  = 3'd1,
    PH_DECODE = 3'd2,
    PH_MEM    = 3'd3,
    PH_WB     = 3'd4,
    PH_HALT   = 3'd5,
    PH_ERROR  = 3'd6
  } phase_e;

  typedef struct packed {
    logic fetch_en;
    logic mem_en;
    logic wb_en;
    logic halted;
  } strobe_t;

  function automatic strobe_t decode_strobes(input phase_e ph);
    strobe_t s;
    s = '0;
    case (ph)
      PH_FETCH:                    s.fetch_en = 1'b1;
      PH_MEM:                      s.mem_en   = 1'b1;
      PH_WB:                       s.wb_en    = 1'b1;
      PH_IDLE, PH_HALT, PH_ERROR:  s.halted   = 1'b1;
      default:                     s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/core_seq_wait_timer.sv
// MEM-phase wait counter: held at zero while cleared, counts while enabled,
// flags expiry on the last cycle allowed without an ack.
module core_seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (en)         cnt <= cnt + W'(1);
  end

  assign expired = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_phase_sequencer.sv
// Variable-length phase sequencer: FETCH/DECODE/[MEM...]/WB with run/step/halt
// control, MEM stretch until ack, bus timeout, and cycle/instret counters.
module core_phase_sequencer
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             is_mem,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             halted,
  output logic             bus_error,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  phase_e  state_q, state_d;
  strobe_t strb;
  logic    step_mode, halt_pend, expired, active;

  core_seq_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != PH_MEM),
    .en      (state_q == PH_MEM),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_IDLE: begin
        if (halt_req)         state_d = PH_HALT;
        else if (run || step) state_d = PH_FETCH;
      end
      PH_FETCH:  state_d = PH_DECODE;
      PH_DECODE: state_d = is_mem ? PH_MEM : PH_WB;
      PH_MEM: begin
        if (mem_ready)    state_d = PH_WB;
        else if (expired) state_d = PH_ERROR;
      end
      PH_WB: begin
        if (halt_pend || halt_req)  state_d = PH_HALT;
        else if (step_mode || !run) state_d = PH_IDLE;
        else                        state_d = PH_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    strb   = decode_strobes(state_q);
    active = (state_q == PH_FETCH) || (state_q == PH_DECODE) ||
             (state_q == PH_MEM)   || (state_q == PH_WB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PH_IDLE;
      step_mode <= 1'b0;
      halt_pend <= 1'b0;
      bus_error <= 1'b0;
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      state_q <= state_d;
      // run has priority over step, so a step issued while running is a no-op
      if (state_q == PH_IDLE && state_d == PH_FETCH) step_mode <= !run;
      if (state_q == PH_WB)
        halt_pend <= 1'b0;
      else if (halt_req && active)
        halt_pend <= 1'b1;
      if (state_d == PH_ERROR) bus_error <= 1'b1;
      if (active)              cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state_q == PH_WB)    instret   <= instret + CNT_W'(1);
    end
  end

  assign fetch_en = strb.fetch_en;
  assign mem_en   = strb.mem_en;
  assign wb_en    = strb.wb_en;
  assign halted   = strb.halted;
  assign phase    = state_q;

endmodule

// File: tb/tb_core_phase_sequencer.sv
// Scoreboard bench: stimulus queues expected snapshots and retirements; a
// negedge monitor pops and compares them against the sequencer outputs.
module tb_core_phase_sequencer;
  localparam int S_PH = 0, S_FE = 1, S_ME = 2, S_WB = 3, S_HLT = 4, S_BE = 5;
  localparam int S_CYC = 6, S_IR = 7, S_NF = 8, S_NM = 9, S_NW = 10;

  typedef struct {int cyc; int sig; logic [31:0] val; string name;} chk_t;
  typedef struct {int len; int ir;} ret_t;

  logic        clk, rst_n, run, step, halt_req, is_mem, mem_ready;
  logic        fetch_en, mem_en, wb_en, halted, bus_error;
  logic [2:0]  phase;
  logic [31:0] cycle_cnt, instret;

  chk_t chk_q[$];
  ret_t ret_q[$];
  int   cyc = 0, f_cyc = 0, n_fetch = 0, n_mem = 0, n_wb = 0;
  int   total = 0, bad = 0;
  logic end_req = 1'b0, end_done = 1'b0;

  core_phase_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .is_mem(is_mem), .mem_ready(mem_ready), .fetch_en(fetch_en), .mem_en(mem_en),
    .wb_en(wb_en), .halted(halted), .bus_error(bus_error), .phase(phase),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_PH:    return 32'(phase);
      S_FE:    return 32'(fetch_en);
      S_ME:    return 32'(mem_en);
      S_WB:    return 32'(wb_en);
      S_HLT:   return 32'(halted);
      S_BE:    return 32'(bus_error);
      S_CYC:   return cycle_cnt;
      S_IR:    return instret;
      S_NF:    return 32'(n_fetch);
      S_NM:    return 32'(n_mem);
      default: return 32'(n_wb);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t c;
    ret_t r;
    int   lat;
    logic [31:0] a;
    if (fetch_en) begin n_fetch++; f_cyc = cyc; end
    if (mem_en) n_mem++;
    if (wb_en) begin
      n_wb++;
      total++;
      if (ret_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_wb cyc=%0d got wb_en=1 exp no retirement", cyc);
      end else begin
        r   = ret_q.pop_front();
        lat = cyc - f_cyc + 1;
        if (lat != r.len || instret != 32'(r.ir)) begin
          bad++;
          $display("FAIL retire cyc=%0d got len=%0d instret=%0d exp len=%0d instret=%0d",
                   cyc, lat, instret, r.len, r.ir);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      c = chk_q.pop_front();
      a = actual(c.sig);
      total++;
      if (a !== c.val) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%0d exp=%0d", c.name, cyc, a, c.val);
      end
    end
    if (end_req && !end_done) begin
      total++;
      if (ret_q.size() != 0 || chk_q.size() != 0) begin
        bad++;
        $display("FAIL drain got ret=%0d chk=%0d pending exp 0", ret_q.size(), chk_q.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int sig, input logic [31:0] v, input string nm);
    chk_t c;
    c.cyc = cyc; c.sig = sig; c.val = v; c.name = nm;
    chk_q.push_back(c);
  endtask

  task automatic exp_ret(input int len, input int ir);
    ret_t r;
    r.len = len; r.ir = ir;
    ret_q.push_back(r);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; is_mem = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    ex(S_PH, 0, "rst_phase"); ex(S_HLT, 1, "rst_halted"); ex(S_FE, 0, "rst_fetch");
    ex(S_ME, 0, "rst_mem"); ex(S_WB, 0, "rst_wb"); ex(S_BE, 0, "rst_buserr");
    ex(S_CYC, 0, "rst_cycle"); ex(S_IR, 0, "rst_instret");

    // free-run, non-memory instructions
    rst_n = 1'b1; run = 1'b1;
    for (int i = 0; i < 10; i++) exp_ret(3, i);
    tick();
    for (int i = 0; i < 30; i++) begin
      ex(S_FE, 32'((i % 3) == 0), "run_fetch");
      ex(S_WB, 32'((i % 3) == 2), "run_wb");
      if (i == 29) run = 1'b0;
      tick();
    end
    ex(S_PH, 0, "run_idle"); ex(S_IR, 10, "run_instret"); ex(S_CYC, 30, "run_cycle");
    ex(S_NM, 0, "run_no_mem"); ex(S_NF, 10, "run_nfetch");

    // memory instruction stretched to 5 MEM cycles; run drops mid-instruction
    run = 1'b1; is_mem = 1'b1; mem_ready = 1'b0;
    exp_ret(8, 10);
    tick(); ex(S_PH, 1, "mem_fetch_ph");
    tick(); ex(S_PH, 2, "mem_decode_ph"); run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); ex(S_ME, 1, "mem_en_hold");
      if (i == 4) mem_ready = 1'b1;
    end
    tick(); ex(S_WB, 1, "mem_wb"); ex(S_ME, 0, "mem_en_drop");
    mem_ready = 1'b0; is_mem = 1'b0;
    tick(); ex(S_PH, 0, "mem_idle"); ex(S_IR, 11, "mem_instret");
    ex(S_CYC, 38, "mem_cycle"); ex(S_NM, 5, "mem_count");

    // single-step: three steps, middle one a 1-cycle-ack memory access
    for (int k = 0; k < 3; k++) begin
      is_mem = (k == 1); mem_ready = (k == 1);
      exp_ret((k == 1) ? 4 : 3, 11 + k);
      step = 1'b1;
      tick(); ex(S_PH, 1, "step_fetch");
      tick(); step = 1'b0;
      repeat (8) tick();
      ex(S_PH, 0, "step_idle");
      tick();
    end
    is_mem = 1'b0; mem_ready = 1'b0;
    ex(S_IR, 14, "step_instret"); ex(S_CYC, 48, "step_cycle");
    ex(S_NF, 14, "step_nfetch"); ex(S_NW, 14, "step_nwb");

    // halt pulse in DECODE: instruction retires, then HALT is terminal
    run = 1'b1;
    exp_ret(3, 14);
    tick();
    tick(); ex(S_PH, 2, "halt_decode_ph"); halt_req = 1'b1;
    tick(); ex(S_WB, 1, "halt_wb"); halt_req = 1'b0;
    tick(); ex(S_PH, 5, "halt_phase"); ex(S_HLT, 1, "halt_halted");
    for (int i = 0; i < 50; i++) begin
      step = 1'(i % 2);
      tick();
    end
    step = 1'b0;
    ex(S_PH, 5, "halt_stays"); ex(S_NF, 15, "halt_nfetch");
    ex(S_IR, 15, "halt_instret"); ex(S_CYC, 51, "halt_cycle");

    // reset back to IDLE, then reset again mid-MEM
    rst_n = 1'b0; run = 1'b0;
    tick(); ex(S_PH, 0, "rst2_phase"); ex(S_IR, 0, "rst2_instret"); ex(S_HLT, 1, "rst2_halted");
    rst_n = 1'b1; run = 1'b1; is_mem = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();
    tick(); ex(S_PH, 3, "mid_mem_ph");
    rst_n = 1'b0;
    tick(); ex(S_PH, 0, "midrst_phase"); ex(S_ME, 0, "midrst_mem");
    ex(S_IR, 0, "midrst_instret"); ex(S_CYC, 0, "midrst_cycle"); ex(S_BE, 0, "midrst_buserr");
    rst_n = 1'b1;
    tick(); ex(S_FE, 1, "restart_fetch");

    // no ack: timeout after the 8th MEM cycle
    tick();
    for (int i = 0; i < 8; i++) begin
      tick(); ex(S_ME, 1, "to_mem_en");
    end
    tick(); ex(S_PH, 6, "to_phase"); ex(S_BE, 1, "to_buserr"); ex(S_HLT, 1, "to_halted");
    ex(S_ME, 0, "to_mem_drop"); ex(S_IR, 0, "to_instret"); ex(S_CYC, 10, "to_cycle");
    for (int i = 0; i < 20; i++) begin
      run = 1'(i % 2); step = !run;
      tick();
    end
    run = 1'b0; step = 1'b0;
    ex(S_PH, 6, "err_stays"); ex(S_BE, 1, "err_buserr"); ex(S_CYC, 10, "err_cycle");
    ex(S_NW, 15, "err_nwb"); ex(S_NM, 16, "err_nmem"); ex(S_NF, 17, "err_nfetch");

    tick();
    end_req = 1'b1;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
